vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator, the successor to the fixed 640x480 sync logic in the demo display core.
- Generates hsync/vsync with configurable timing and polarity, plus a display-enable and pixel coordinates.
- Adds a pixel-clock-enable divider from the system clock, line/frame strobes, a frame counter and a soft-restart enable.
- Instantiated inside display cores, driven from wb_clk_i; the wrapper routes hsync/vsync to user IO pads.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
CLK_DIV, 1, system clocks per pixel (>=1)
CW, 12, coordinate counter width
FW, 8, frame counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run when 1; synchronous soft restart when 0
pix_stb  out  1  one-clk pulse coincident with every output update
hsync  out  1  horizontal sync, level per H_POL
vsync  out  1  vertical sync, level per V_POL
de  out  1  display enable (active region)
x  out  CW  current pixel column, 0..H_TOTAL-1
y  out  CW  current line, 0..V_TOTAL-1
line_start  out  1  high during the update presenting x=0
frame_start  out  1  high during the update presenting x=0,y=0
frame_cnt  out  FW  completed-frame count, wraps

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration-time checks: CLK_DIV>=1; H_TOTAL <= 2^CW; V_TOTAL <= 2^CW; every timing parameter >= 1.
- Divider: div counts 0..CLK_DIV-1 while enable=1. A tick occurs in a cycle with div==CLK_DIV-1. For CLK_DIV=1, every enabled cycle is a tick.
- Position state: internal (h,v). On a tick, all outputs are registered from the current (h,v), then h increments. When h wraps from H_TOTAL-1 to 0, v increments. When v wraps from V_TOTAL-1 to 0, frame_cnt increments.
- Latency: outputs lag the position state by one tick. Outputs change only on the clk edge ending a tick cycle. pix_stb is high for exactly the clk following that edge.
- Decode, all registered:
  - de = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; changes only on updates with x=0
  - output level = active ? POL : ~POL
  - x=h, y=v, line_start=(h==0), frame_start=(h==0 && v==0)
- frame_cnt: the new value becomes visible on the same update as the next frame_start. It reads 0 throughout the first frame after reset and wraps at 2^FW-1 -> 0.
- Reset (async, immediate, no clock needed) sets:
  - div, h, v and frame_cnt to 0
  - pix_stb, de, line_start and frame_start to 0
  - x and y to 0
  - hsync = ~H_POL, vsync = ~V_POL
- enable=0, sampled on a clk edge:
  - div, h and v clear to 0; all outputs return to their reset values; no pix_stb.
  - frame_cnt holds its value.
- Re-enable: the first tick after enable rises presents (0,0) with frame_start=1. frame_cnt does not increment, because no wrap occurred.
- enable deasserted in the same cycle as a tick: the clear wins and no update occurs.
- No other modes; timing is fixed per instance.

Decomposition:
- Shared package vga_pkg holds:
  - localparam timing sets VGA_640x480_60 (25 MHz) and SVGA_800x600_60 (40 MHz)
  - polarity constants SYNC_NEG=0, SYNC_POS=1
- One natural sub-module, pix_clk_en: the CLK_DIV divider with synchronous clear, emitting the tick.
- Counters and decode stay in vga_timing_gen.

Test Plan:
Small bench config unless stated: H=8/2/3/3 (H_TOTAL 16), V=4/1/2/1 (V_TOTAL 8), CLK_DIV=2, POL=0, enable=1.
1. Release reset -> first pix_stb on clk 2; x=0, y=0, de=1, line_start=1, frame_start=1, hsync=1, vsync=1, frame_cnt=0. pix_stb then every 2 clks.
2. Line 0 -> de=1 for x=0..7 and 0 for x=8..15; hsync=0 exactly for x=10..12 (3 strobes); line_start only at x=0.
3. Full frame -> vsync=0 only for y=5,6 (32 strobes), toggling on x=0 updates; frame_cnt=1 at second frame_start (strobe 129, clk 258); frame_cnt=255 wraps to 0 after 256 frames (FW=8).
4. Drop enable at x=5, y=2 for 3 clks -> outputs idle next clk, pix_stb=0. Re-enable -> next tick presents (0,0), frame_start=1, frame_cnt unchanged.
5. Assert reset mid-frame with no clk edge -> all outputs go to reset values immediately; frame_cnt=0.
6. H_POL=1, V_POL=1, CLK_DIV=1, default 640x480 -> hsync high for x=656..751, vsync high for y=490..491, pix_stb every clk, 420000 clks per frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster-timing definitions for the display cores: standard timing
// sets, sync polarity constants and the sync level helper.
package vga_pkg;

  // Sync polarity: level driven while the pulse is active
  localparam logic SYNC_NEG = 1'b0;
  localparam logic SYNC_POS = 1'b1;

  // One complete raster timing set, pixel counts in pixels/lines
  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        h_pol;
    logic        v_pol;
    logic [31:0] pix_khz;
  } vga_timing_t;

  // 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam vga_timing_t VGA_640x480_60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
    h_pol: SYNC_NEG, v_pol: SYNC_NEG, pix_khz: 32'd25000
  };

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam vga_timing_t SVGA_800x600_60 = '{
    h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
    v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
    h_pol: SYNC_POS, v_pol: SYNC_POS, pix_khz: 32'd40000
  };

  // Pad level for a sync signal: the polarity when active, its inverse otherwise
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// Pixel clock-enable divider: one tick every CLK_DIV system clocks,
// restarted from phase 0 whenever clr is held.
module pix_clk_en #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // A clear in the same cycle suppresses the tick so no update can slip out
  assign tick = ~clr && (div_q == DIV_LAST);

  // Next divider phase: clear, wrap at the last phase, or count up
  always_comb begin
    div_d = div_q;
    if (clr) begin
      div_d = {DW{1'b0}};
    end else if (div_q == DIV_LAST) begin
      div_d = {DW{1'b0}};
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Divider phase register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= {DW{1'b0}};
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: position counters, sync/enable
// decode and frame counting, all outputs registered one tick behind the
// internal position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 1,
  parameter int CW       = 12,
  parameter int FW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_stb,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject timing that cannot be represented before anything is built
  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_param_err
    $error("vga_timing_gen: illegal timing parameters");
  end

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
  localparam logic          H_POL_C  = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic          V_POL_C  = (V_POL != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};

  logic tick_s;
  logic h_act_s, v_act_s, hs_win_s, vs_win_s;

  // Internal position and frame count
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [FW-1:0] frames_q, frames_d;

  // Registered outputs
  logic          pix_stb_q, pix_stb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;

  pix_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_clk_en (
    .clk   (clk),
    .reset (reset),
    .clr   (~enable),
    .tick  (tick_s)
  );

  // Region decode of the current position
  assign h_act_s  = (h_q < H_ACT_C);
  assign v_act_s  = (v_q < V_ACT_C);
  assign hs_win_s = (h_q >= HS_BEG_C) && (h_q < HS_END_C);
  assign vs_win_s = (v_q >= VS_BEG_C) && (v_q < VS_END_C);

  // Next state: soft restart when disabled, otherwise present and advance on a tick
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frames_d      = frames_q;
    pix_stb_d     = 1'b0;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    frame_cnt_d   = frame_cnt_q;
    if (!enable) begin
      // Restart: position and outputs idle, completed-frame count kept
      h_d           = ZERO_C;
      v_d           = ZERO_C;
      hsync_d       = ~H_POL_C;
      vsync_d       = ~V_POL_C;
      de_d          = 1'b0;
      x_d           = ZERO_C;
      y_d           = ZERO_C;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end else if (tick_s) begin
      pix_stb_d     = 1'b1;
      hsync_d       = sync_level(hs_win_s, H_POL_C);
      vsync_d       = sync_level(vs_win_s, V_POL_C);
      de_d          = h_act_s && v_act_s;
      x_d           = h_q;
      y_d           = v_q;
      line_start_d  = (h_q == ZERO_C);
      frame_start_d = (h_q == ZERO_C) && (v_q == ZERO_C);
      // The count bumped at the last pixel surfaces with the next frame_start
      frame_cnt_d   = frames_q;
      if (h_q == H_LAST_C) begin
        h_d = ZERO_C;
        if (v_q == V_LAST_C) begin
          v_d      = ZERO_C;
          frames_d = frames_q + FW'(1);
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end else begin
      pix_stb_d = 1'b0;
    end
  end

  // Position, frame count and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q           <= ZERO_C;
      v_q           <= ZERO_C;
      frames_q      <= {FW{1'b0}};
      pix_stb_q     <= 1'b0;
      hsync_q       <= ~H_POL_C;
      vsync_q       <= ~V_POL_C;
      de_q          <= 1'b0;
      x_q           <= ZERO_C;
      y_q           <= ZERO_C;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= {FW{1'b0}};
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frames_q      <= frames_d;
      pix_stb_q     <= pix_stb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign pix_stb     = pix_stb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two instances (divided negative-sync, undivided
// positive-sync with a full-width counter) under random enable drops and
// asynchronous resets, checked against a pixel-index arithmetic model.
module tb_vga_timing_gen;

  // Instance 0 = small divided config, instance 1 = positive sync, CLK_DIV=1
  localparam int P_HA  [2] = '{8, 9};
  localparam int P_HF  [2] = '{2, 2};
  localparam int P_HS  [2] = '{3, 3};
  localparam int P_HB  [2] = '{3, 2};
  localparam int P_VA  [2] = '{4, 3};
  localparam int P_VF  [2] = '{1, 1};
  localparam int P_VS  [2] = '{2, 2};
  localparam int P_VB  [2] = '{1, 1};
  localparam int P_HP  [2] = '{0, 1};
  localparam int P_VP  [2] = '{0, 1};
  localparam int P_DIV [2] = '{2, 1};
  localparam int P_FW  [2] = '{4, 3};

  logic clk, reset, en_a, en_b;

  logic        a_stb, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [11:0] a_x, a_y;
  logic [3:0]  a_fc;
  logic        b_stb, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [3:0]  b_x, b_y;
  logic [2:0]  b_fc;

  int errors = 0;
  int checks = 0;

  // Model state: clocks and presented pixels since restart, frame base
  int k [2], n [2], base [2];
  int e_stb [2], e_hs [2], e_vs [2], e_de [2], e_x [2], e_y [2];
  int e_ls [2], e_fs [2], e_fc [2];

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(2), .CW(12), .FW(4)
  ) u_dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .pix_stb(a_stb),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(9), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .CLK_DIV(1), .CW(4), .FW(3)
  ) u_dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .pix_stb(b_stb),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_idle(input int i);
    e_stb[i] = 0;
    e_hs[i]  = 1 - P_HP[i];
    e_vs[i]  = 1 - P_VP[i];
    e_de[i]  = 0;
    e_x[i]   = 0;
    e_y[i]   = 0;
    e_ls[i]  = 0;
    e_fs[i]  = 0;
  endtask

  task automatic model_reset(input int i);
    k[i]    = 0;
    n[i]    = 0;
    base[i] = 0;
    e_fc[i] = 0;
    model_idle(i);
  endtask

  // One clock edge of the reference: pixel n of a restart run is at
  // column n mod H_TOTAL, line (n div H_TOTAL) mod V_TOTAL
  task automatic model_step(input int i, input logic en, input logic rst);
    int ht, vt, ft, hx, vy;
    ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
    vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
    ft = ht * vt;
    if (rst) begin
      model_reset(i);
    end else if (!en) begin
      base[i] = base[i] + n[i] / ft;
      k[i] = 0;
      n[i] = 0;
      model_idle(i);
    end else begin
      if ((k[i] % P_DIV[i]) == P_DIV[i] - 1) begin
        hx = n[i] % ht;
        vy = (n[i] / ht) % vt;
        e_stb[i] = 1;
        e_x[i]   = hx;
        e_y[i]   = vy;
        e_de[i]  = (hx < P_HA[i] && vy < P_VA[i]) ? 1 : 0;
        e_hs[i]  = (hx >= P_HA[i] + P_HF[i] && hx < P_HA[i] + P_HF[i] + P_HS[i])
                   ? P_HP[i] : 1 - P_HP[i];
        e_vs[i]  = (vy >= P_VA[i] + P_VF[i] && vy < P_VA[i] + P_VF[i] + P_VS[i])
                   ? P_VP[i] : 1 - P_VP[i];
        e_ls[i]  = (hx == 0) ? 1 : 0;
        e_fs[i]  = (hx == 0 && vy == 0) ? 1 : 0;
        e_fc[i]  = (base[i] + n[i] / ft) % (1 << P_FW[i]);
        n[i]++;
      end else begin
        e_stb[i] = 0;
      end
      k[i]++;
    end
  endtask

  task automatic compare(input int i);
    if (i == 0) begin
      check("A.pix_stb", int'(a_stb), e_stb[0]);
      check("A.hsync", int'(a_hs), e_hs[0]);
      check("A.vsync", int'(a_vs), e_vs[0]);
      check("A.de", int'(a_de), e_de[0]);
      check("A.x", int'(a_x), e_x[0]);
      check("A.y", int'(a_y), e_y[0]);
      check("A.line_start", int'(a_ls), e_ls[0]);
      check("A.frame_start", int'(a_fs), e_fs[0]);
      check("A.frame_cnt", int'(a_fc), e_fc[0]);
    end else begin
      check("B.pix_stb", int'(b_stb), e_stb[1]);
      check("B.hsync", int'(b_hs), e_hs[1]);
      check("B.vsync", int'(b_vs), e_vs[1]);
      check("B.de", int'(b_de), e_de[1]);
      check("B.x", int'(b_x), e_x[1]);
      check("B.y", int'(b_y), e_y[1]);
      check("B.line_start", int'(b_ls), e_ls[1]);
      check("B.frame_start", int'(b_fs), e_fs[1]);
      check("B.frame_cnt", int'(b_fc), e_fc[1]);
    end
  endtask

  task automatic edge_and_check();
    @(posedge clk);
    model_step(0, en_a, reset);
    model_step(1, en_b, reset);
    #1;
    compare(0);
    compare(1);
  endtask

  initial begin
    int off_a, off_b;
    off_a = 0;
    off_b = 0;
    reset = 1'b1;
    en_a  = 1'b1;
    en_b  = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    compare(0);
    compare(1);
    edge_and_check();
    #2 reset = 1'b0;

    // Free-running: several frames, frame counter wraps in both instances
    for (int c = 0; c < 6000; c++) begin
      edge_and_check();
    end

    // Random enable drops and asynchronous mid-cycle resets
    for (int c = 0; c < 8000; c++) begin
      edge_and_check();
      #2;
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        compare(0);
        compare(1);
      end
      if (off_a > 0) begin
        off_a--;
        if (off_a == 0) en_a = 1'b1;
      end else if ($urandom_range(0, 63) == 0) begin
        en_a  = 1'b0;
        off_a = $urandom_range(1, 4);
      end
      if (off_b > 0) begin
        off_b--;
        if (off_b == 0) en_b = 1'b1;
      end else if ($urandom_range(0, 63) == 0) begin
        en_b  = 1'b0;
        off_b = $urandom_range(1, 4);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
